// File: rtl/clipped_box_drawer.sv
// clipped_box_drawer
// Accepts one rectangle command over a valid/ready handshake and rasterises it
// row-major into single-pixel plot requests. Boxes are clipped to the screen.
// Fill mode plots every position. Outline mode plots only the 1-pixel border
// of the unclipped box. Pixel output honours downstream backpressure, and done
// pulses for one cycle when a command completes.
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   s_valid/s_ready   command handshake (s_ready high while idle)
//   in_box_x/y/w/h    top-left corner and size of the box
//   in_box_color      box colour
//   in_mode           0 = fill, 1 = outline
//   pix_ready         downstream accepts the presented pixel
//   plot              pixel valid
//   vga_x/vga_y       pixel coordinates
//   colour            pixel colour
//   done              one-cycle completion pulse
module clipped_box_drawer #(
  parameter int COORD_W       = 9,
  parameter int COLOR_W       = 3,
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 240
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [COORD_W-1:0] in_box_x,
  input  logic [COORD_W-1:0] in_box_y,
  input  logic [COORD_W-1:0] in_box_w,
  input  logic [COORD_W-1:0] in_box_h,
  input  logic [COLOR_W-1:0] in_box_color,
  input  logic               in_mode,
  input  logic               pix_ready,
  output logic               plot,
  output logic [COORD_W-1:0] vga_x,
  output logic [COORD_W-1:0] vga_y,
  output logic [COLOR_W-1:0] colour,
  output logic               done
);

  // One extra bit so that x+w and y+h can never wrap.
  localparam int EW = COORD_W + 1;
  localparam logic [EW-1:0] SCR_W = EW'(SCREEN_WIDTH);
  localparam logic [EW-1:0] SCR_H = EW'(SCREEN_HEIGHT);

  typedef enum logic [1:0] {IDLE, CLIP, DRAW, DONE} state_t;

  state_t             r_state;
  state_t             w_stateNext;
  logic [COORD_W-1:0] r_x, r_y, r_w, r_h;
  logic [COLOR_W-1:0] r_color;
  logic               r_mode;
  logic [EW-1:0]      r_xEnd, r_yEnd;
  logic [COORD_W-1:0] r_iterX, r_iterY;

  logic [EW-1:0]      w_xSum, w_ySum, w_xClip, w_yClip;
  logic [EW-1:0]      w_iterXNext, w_iterYNext;
  logic               w_reject, w_lastCol, w_lastRow, w_border;
  logic               w_plot, w_advance, w_ready, w_done;

  assign w_xSum  = {1'b0, r_x} + {1'b0, r_w};
  assign w_ySum  = {1'b0, r_y} + {1'b0, r_h};
  assign w_xClip = (w_xSum > SCR_W) ? SCR_W : w_xSum;
  assign w_yClip = (w_ySum > SCR_H) ? SCR_H : w_ySum;

  assign w_reject = (r_w == '0) || (r_h == '0) ||
                    ({1'b0, r_x} >= SCR_W) || ({1'b0, r_y} >= SCR_H);

  // "iter+1" compared against an exclusive end avoids subtracting 1 from a
  // possibly zero bound.
  assign w_iterXNext = {1'b0, r_iterX} + EW'(1);
  assign w_iterYNext = {1'b0, r_iterY} + EW'(1);
  assign w_lastCol   = (w_iterXNext == r_xEnd);
  assign w_lastRow   = (w_iterYNext == r_yEnd);

  // Border of the unclipped box, so clipped edges are not drawn as outline.
  assign w_border = (r_iterX == r_x) || (w_iterXNext == w_xSum) ||
                    (r_iterY == r_y) || (w_iterYNext == w_ySum);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  // Next-state and output decode. Plotted pixels wait for pix_ready, and
  // blank outline interior positions move on immediately.
  always_comb begin
    w_stateNext = r_state;
    w_ready     = 1'b0;
    w_plot      = 1'b0;
    w_done      = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (s_valid) w_stateNext = CLIP;
      end
      CLIP: begin
        w_stateNext = w_reject ? DONE : DRAW;
      end
      DRAW: begin
        w_plot    = !r_mode || w_border;
        w_advance = !w_plot || pix_ready;
        if (w_advance && w_lastCol && w_lastRow) w_stateNext = DONE;
      end
      DONE: begin
        w_done      = 1'b1;
        w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Command latch, clip bounds and the row-major iterator.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_color <= '0;
      r_mode  <= 1'b0;
      r_xEnd  <= '0;
      r_yEnd  <= '0;
      r_iterX <= '0;
      r_iterY <= '0;
    end else begin
      if (r_state == IDLE && s_valid) begin
        r_x     <= in_box_x;
        r_y     <= in_box_y;
        r_w     <= in_box_w;
        r_h     <= in_box_h;
        r_color <= in_box_color;
        r_mode  <= in_mode;
      end
      if (r_state == CLIP) begin
        r_xEnd  <= w_xClip;
        r_yEnd  <= w_yClip;
        r_iterX <= r_x;
        r_iterY <= r_y;
      end
      // On the final position the iterator is left alone so the last pixel
      // stays visible on the bus.
      if (r_state == DRAW && w_advance && !(w_lastCol && w_lastRow)) begin
        if (w_lastCol) begin
          r_iterX <= r_x;
          r_iterY <= r_iterY + 1'b1;
        end else begin
          r_iterX <= r_iterX + 1'b1;
        end
      end
    end
  end

  assign s_ready = w_ready;
  assign plot    = w_plot;
  assign done    = w_done;
  assign vga_x   = r_iterX;
  assign vga_y   = r_iterY;
  assign colour  = r_color;

endmodule

// File: tb/tb_clipped_box_drawer.sv
// tb_clipped_box_drawer
// Self-checking bench for clipped_box_drawer. A behavioural model walks the
// clipped box with plain loops and builds the ordered list of pixels that must
// be plotted. Directed commands are followed by randomized ones with random
// downstream backpressure.
module tb_clipped_box_drawer;

  localparam int COORD_W = 9;
  localparam int COLOR_W = 3;
  localparam int SW      = 320;
  localparam int SH      = 240;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic [COORD_W-1:0] in_box_x = '0, in_box_y = '0, in_box_w = '0, in_box_h = '0;
  logic [COLOR_W-1:0] in_box_color = '0;
  logic               in_mode = 1'b0;
  logic               pix_ready = 1'b1;
  logic               plot;
  logic [COORD_W-1:0] vga_x, vga_y;
  logic [COLOR_W-1:0] colour;
  logic               done;

  int nChecks = 0;
  int nErrors = 0;

  clipped_box_drawer #(
    .COORD_W(COORD_W), .COLOR_W(COLOR_W),
    .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH)
  ) dut (
    .clock(clock), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready),
    .in_box_x(in_box_x), .in_box_y(in_box_y),
    .in_box_w(in_box_w), .in_box_h(in_box_h),
    .in_box_color(in_box_color), .in_mode(in_mode),
    .pix_ready(pix_ready), .plot(plot),
    .vga_x(vga_x), .vga_y(vga_y), .colour(colour), .done(done)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // readyMode: 0 = pix_ready always 1, 1 = random, 2 = stall (1,0) three times.
  task automatic applyStimulus(input int bx, input int by, input int bw, input int bh,
                               input int bc, input int bm, input int readyMode);
    int  expX[$];
    int  expY[$];
    int  nPos, stalls, holdCnt, sx, sy, sc, xe, ye;
    bit  stallPending, finished, border;

    nPos = 0; stalls = 0; holdCnt = 0; stallPending = 0; finished = 0;
    sx = 0; sy = 0; sc = 0;
    xe = (bx + bw < SW) ? bx + bw : SW;
    ye = (by + bh < SH) ? by + bh : SH;
    if (!(bw == 0 || bh == 0 || bx >= SW || by >= SH)) begin
      for (int yy = by; yy < ye; yy++) begin
        for (int xx = bx; xx < xe; xx++) begin
          nPos++;
          border = (bm == 0) || (xx == bx) || (xx == bx + bw - 1) ||
                   (yy == by) || (yy == by + bh - 1);
          if (border) begin
            expX.push_back(xx);
            expY.push_back(yy);
          end
        end
      end
    end

    @(negedge clock);
    checkOutput("idleReady", s_ready, 1);
    s_valid      = 1'b1;
    in_box_x     = COORD_W'(bx);
    in_box_y     = COORD_W'(by);
    in_box_w     = COORD_W'(bw);
    in_box_h     = COORD_W'(bh);
    in_box_color = COLOR_W'(bc);
    in_mode      = bm[0];
    @(posedge clock);
    #1;
    s_valid      = 1'b0;
    in_box_x     = COORD_W'($urandom);
    in_box_y     = COORD_W'($urandom);
    in_box_w     = COORD_W'($urandom);
    in_box_h     = COORD_W'($urandom);
    in_box_color = COLOR_W'($urandom);
    in_mode      = 1'($urandom);

    for (int c = 1; c <= 5000; c++) begin
      @(negedge clock);
      if (c == 1) checkOutput("busyReady", s_ready, 0);
      if (stallPending) begin
        checkOutput("holdPlot", plot, 1);
        checkOutput("holdX", vga_x, sx);
        checkOutput("holdY", vga_y, sy);
        checkOutput("holdColour", colour, sc);
      end
      if (done) begin
        checkOutput("doneCycle", c, 2 + nPos + stalls);
        checkOutput("leftoverPixels", expX.size(), 0);
        finished = 1;
        break;
      end
      case (readyMode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = ($urandom_range(0, 3) != 0);
        default: pix_ready = !(plot && vga_x == 1 && vga_y == 0 && holdCnt < 3);
      endcase
      if (plot && vga_x == 1 && vga_y == 0) holdCnt++;
      stallPending = plot && !pix_ready;
      if (stallPending) begin
        stalls++;
        sx = vga_x; sy = vga_y; sc = colour;
      end
      if (plot && pix_ready) begin
        if (expX.size() == 0) begin
          checkOutput("extraPixel", 1, 0);
        end else begin
          checkOutput("pixX", vga_x, expX.pop_front());
          checkOutput("pixY", vga_y, expY.pop_front());
          checkOutput("pixColour", colour, bc);
        end
      end
    end
    if (!finished) checkOutput("doneTimeout", 0, 1);
    if (readyMode == 2) checkOutput("holdCount", holdCnt, 4);
    pix_ready = 1'b1;
    @(negedge clock);
    checkOutput("readyAfterDone", s_ready, 1);
    checkOutput("doneIsPulse", done, 0);
  endtask

  initial begin
    int rx, ry, rw, rh;
    #12;
    checkOutput("rstReady", s_ready, 1);
    checkOutput("rstPlot", plot, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstX", vga_x, 0);
    checkOutput("rstY", vga_y, 0);
    checkOutput("rstColour", colour, 0);
    @(negedge clock);
    reset = 1'b0;

    applyStimulus(5, 7, 3, 2, 5, 0, 0);
    applyStimulus(0, 0, 4, 3, 2, 1, 0);
    applyStimulus(318, 238, 5, 5, 6, 0, 0);
    applyStimulus(10, 10, 0, 4, 1, 0, 0);
    applyStimulus(320, 10, 4, 4, 1, 0, 0);
    applyStimulus(10, 240, 4, 4, 1, 1, 0);
    applyStimulus(0, 0, 3, 1, 4, 0, 2);
    applyStimulus(30, 40, 1, 4, 7, 1, 0);
    applyStimulus(316, 100, 8, 3, 3, 1, 1);

    // Reset in the middle of a large fill.
    @(negedge clock);
    s_valid = 1'b1;
    in_box_x = 20; in_box_y = 20; in_box_w = 10; in_box_h = 10;
    in_box_color = 3; in_mode = 1'b0;
    @(posedge clock);
    #1 s_valid = 1'b0;
    repeat (5) @(posedge clock);
    #2;
    checkOutput("preRstPlot", plot, 1);
    reset = 1'b1;
    #1;
    checkOutput("midRstPlot", plot, 0);
    checkOutput("midRstDone", done, 0);
    checkOutput("midRstReady", s_ready, 1);
    checkOutput("midRstX", vga_x, 0);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(2, 2, 1, 1, 5, 0, 0);

    for (int i = 0; i < 60; i++) begin
      rx = ($urandom_range(0, 3) == 0) ? $urandom_range(300, 330) : $urandom_range(0, 40);
      ry = ($urandom_range(0, 3) == 0) ? $urandom_range(220, 250) : $urandom_range(0, 40);
      rw = $urandom_range(0, 12);
      rh = $urandom_range(0, 12);
      if ($urandom_range(0, 9) == 0) begin
        rw = $urandom_range(250, 511);
        rh = $urandom_range(1, 3);
      end
      applyStimulus(rx, ry, rw, rh, $urandom_range(0, 7), $urandom_range(0, 1), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
    $finish;
  end

endmodule
